// File: rtl/blocpu_pkg.sv
// Shared definitions for the blocpu execution unit: COMBINE opcodes, flag bit
// positions and the execution FSM state encoding.
package blocpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBB = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } exec_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/blocpu_alu.sv
// Combinational COMBINE datapath: full single-cycle result/flags for every
// opcode plus the one-bit shift step used by the bit-serial shifter.
module blocpu_alu
  import blocpu_pkg::*;
#(
  parameter int CPU_WIDTH = 8
) (
  input  logic [3:0]           op,
  input  logic [CPU_WIDTH-1:0] a,
  input  logic [CPU_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [CPU_WIDTH-1:0] res,
  output logic [3:0]           flags,
  output logic                 wr_reg,
  output logic                 illegal,
  input  logic [3:0]           step_op,
  input  logic [CPU_WIDTH-1:0] step_in,
  output logic [CPU_WIDTH-1:0] step_res,
  output logic                 step_out
);

  localparam int W = CPU_WIDTH;
  typedef logic [W-1:0] word_t;
  localparam word_t W_MAX = word_t'(W);

  logic [W:0]   ext;
  logic [W-1:0] n_eff;
  logic         c_flag;
  logic         v_flag;
  logic         cin_eff;

  always_comb begin
    ext     = '0;
    res     = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    wr_reg  = 1'b1;
    illegal = 1'b0;
    cin_eff = 1'b0;
    n_eff   = (b > W_MAX) ? W_MAX : b;
    case (op)
      OP_ADD, OP_ADC: begin
        cin_eff = (op == OP_ADC) && cin;
        ext     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin_eff};
        res     = ext[W-1:0];
        c_flag  = ext[W];
        v_flag  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        // Bit W of the widened difference is the borrow out.
        cin_eff = (op == OP_SBB) && cin;
        ext     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin_eff};
        res     = ext[W-1:0];
        c_flag  = ext[W];
        v_flag  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        wr_reg  = (op != OP_CMP);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      // Guard bit on the exit side of the shift captures the last bit out.
      OP_SHL: begin
        ext    = {1'b0, a} << n_eff;
        res    = ext[W-1:0];
        c_flag = ext[W];
      end
      OP_SHR: begin
        ext    = {a, 1'b0} >> n_eff;
        res    = ext[W:1];
        c_flag = ext[0];
      end
      OP_SAR: begin
        ext    = $unsigned($signed({a, 1'b0}) >>> n_eff);
        res    = ext[W:1];
        c_flag = ext[0];
      end
      default: begin
        wr_reg  = 1'b0;
        illegal = 1'b1;
      end
    endcase
    flags = illegal ? 4'b0000 : {v_flag, c_flag, res[W-1], (res == '0)};
  end

  always_comb begin
    step_res = step_in;
    step_out = 1'b0;
    case (step_op)
      OP_SHL: begin
        step_res = {step_in[W-2:0], 1'b0};
        step_out = step_in[W-1];
      end
      OP_SHR: begin
        step_res = {1'b0, step_in[W-1:1]};
        step_out = step_in[0];
      end
      OP_SAR: begin
        step_res = {step_in[W-1], step_in[W-1:1]};
        step_out = step_in[0];
      end
      default: begin
        step_res = step_in;
        step_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/blocpu_exec_unit.sv
// blocpu execution unit: register file, flag register RF and COMBINE ALU with
// optional bit-serial shifter, driven by a valid/ready operation handshake.
module blocpu_exec_unit
  import blocpu_pkg::*;
#(
  parameter int CPU_WIDTH    = 8,
  parameter int REG_COUNT    = 8,
  parameter int SHIFT_SERIAL = 1,
  parameter int RIDX_W       = $clog2(REG_COUNT)
) (
  input  logic                 in_clock,
  input  logic                 in_reset_n,
  input  logic                 in_op_valid,
  output logic                 out_op_ready,
  input  logic [3:0]           in_op,
  input  logic [RIDX_W-1:0]    in_dst,
  input  logic [RIDX_W-1:0]    in_src,
  output logic                 out_done,
  output logic                 out_illegal,
  input  logic                 in_wr_en,
  input  logic [RIDX_W-1:0]    in_wr_addr,
  input  logic [CPU_WIDTH-1:0] in_wr_data,
  input  logic                 in_flags_wr_en,
  input  logic [CPU_WIDTH-1:0] in_flags_data,
  input  logic [RIDX_W-1:0]    in_rd_addr_a,
  output logic [CPU_WIDTH-1:0] out_rd_data_a,
  input  logic [RIDX_W-1:0]    in_rd_addr_b,
  output logic [CPU_WIDTH-1:0] out_rd_data_b,
  output logic [CPU_WIDTH-1:0] out_flags
);

  localparam int W = CPU_WIDTH;
  typedef logic [W-1:0] word_t;
  localparam word_t W_MAX = word_t'(W);

  // Handshake: an operation is taken on a rising edge where in_op_valid and
  // out_op_ready are both high; ready is high exactly while the FSM is IDLE.

  logic [W-1:0]      rg [REG_COUNT];
  logic [3:0]        rf;
  exec_state_t       state;
  logic [W-1:0]      sh_val;
  logic [W-1:0]      sh_cnt;
  logic [3:0]        sh_op;
  logic [RIDX_W-1:0] sh_dst;
  logic              done_q;
  logic              illegal_q;

  logic [W-1:0] op_a, op_b, shift_n;
  logic [W-1:0] alu_res, step_res;
  logic [3:0]   alu_flags;
  logic         alu_wr, alu_illegal, step_out;
  logic         accept, go_serial, shift_last;
  logic         wb_reg, wb_flags;
  logic [RIDX_W-1:0] wb_idx;
  logic [W-1:0] wb_data;
  logic [3:0]   wb_f;
  logic         unused_ok;

  assign op_a       = rg[in_dst];
  assign op_b       = rg[in_src];
  assign shift_n    = (op_b > W_MAX) ? W_MAX : op_b;
  assign accept     = in_op_valid && (state == ST_IDLE);
  assign go_serial  = (SHIFT_SERIAL != 0) && is_shift_op(in_op) && (shift_n != '0);
  assign shift_last = (state == ST_SHIFT) && (sh_cnt == word_t'(1));
  assign unused_ok  = ^in_flags_data;

  blocpu_alu #(.CPU_WIDTH(W)) u_alu (
    .op       (in_op),
    .a        (op_a),
    .b        (op_b),
    .cin      (rf[FLAG_C]),
    .res      (alu_res),
    .flags    (alu_flags),
    .wr_reg   (alu_wr),
    .illegal  (alu_illegal),
    .step_op  (sh_op),
    .step_in  (sh_val),
    .step_res (step_res),
    .step_out (step_out)
  );

  always_comb begin
    wb_reg   = 1'b0;
    wb_flags = 1'b0;
    wb_idx   = in_dst;
    wb_data  = alu_res;
    wb_f     = alu_flags;
    if (shift_last) begin
      wb_reg   = 1'b1;
      wb_flags = 1'b1;
      wb_idx   = sh_dst;
      wb_data  = step_res;
      wb_f     = {1'b0, step_out, step_res[W-1], (step_res == '0)};
    end else if (accept && !go_serial) begin
      wb_reg   = alu_wr;
      wb_flags = !alu_illegal;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state     <= ST_IDLE;
      sh_val    <= '0;
      sh_cnt    <= '0;
      sh_op     <= OP_ADD;
      sh_dst    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (go_serial) begin
              sh_val <= op_a;
              sh_cnt <= shift_n;
              sh_op  <= in_op;
              sh_dst <= in_dst;
              state  <= ST_SHIFT;
            end else begin
              done_q    <= 1'b1;
              illegal_q <= alu_illegal;
            end
          end
        end
        ST_SHIFT: begin
          sh_val <= step_res;
          sh_cnt <= sh_cnt - word_t'(1);
          if (shift_last) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Execution writeback is applied after the external write so it wins.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) rg[i] <= '0;
      rf <= 4'b0000;
    end else begin
      if (in_wr_en) rg[in_wr_addr] <= in_wr_data;
      if (wb_reg) rg[wb_idx] <= wb_data;
      if (in_flags_wr_en) rf <= in_flags_data[3:0];
      if (wb_flags) rf <= wb_f;
    end
  end

  assign out_op_ready  = (state == ST_IDLE);
  assign out_done      = done_q;
  assign out_illegal   = illegal_q;
  assign out_rd_data_a = rg[in_rd_addr_a];
  assign out_rd_data_b = rg[in_rd_addr_b];
  assign out_flags     = word_t'(rf);

endmodule

// File: tb/tb_blocpu_exec_unit.sv
// Bench for blocpu_exec_unit: directed scenarios plus randomized operations
// checked against an arithmetic reference model of registers and flags.
module tb_blocpu_exec_unit;

  localparam int W  = 8;
  localparam int RC = 8;
  localparam int RW = 3;

  logic          in_clock = 1'b0;
  logic          in_reset_n;
  logic          in_op_valid;
  logic          out_op_ready;
  logic [3:0]    in_op;
  logic [RW-1:0] in_dst, in_src;
  logic          out_done, out_illegal;
  logic          in_wr_en;
  logic [RW-1:0] in_wr_addr;
  logic [W-1:0]  in_wr_data;
  logic          in_flags_wr_en;
  logic [W-1:0]  in_flags_data;
  logic [RW-1:0] in_rd_addr_a, in_rd_addr_b;
  logic [W-1:0]  out_rd_data_a, out_rd_data_b, out_flags;

  int checks   = 0;
  int failures = 0;
  int m_rg [RC];
  int m_f;
  logic [W-1:0] exp_q [$];

  blocpu_exec_unit #(.CPU_WIDTH(W), .REG_COUNT(RC), .SHIFT_SERIAL(1)) dut (
    .in_clock       (in_clock),
    .in_reset_n     (in_reset_n),
    .in_op_valid    (in_op_valid),
    .out_op_ready   (out_op_ready),
    .in_op          (in_op),
    .in_dst         (in_dst),
    .in_src         (in_src),
    .out_done       (out_done),
    .out_illegal    (out_illegal),
    .in_wr_en       (in_wr_en),
    .in_wr_addr     (in_wr_addr),
    .in_wr_data     (in_wr_data),
    .in_flags_wr_en (in_flags_wr_en),
    .in_flags_data  (in_flags_data),
    .in_rd_addr_a   (in_rd_addr_a),
    .out_rd_data_a  (out_rd_data_a),
    .in_rd_addr_b   (in_rd_addr_b),
    .out_rd_data_b  (out_rd_data_b),
    .out_flags      (out_flags)
  );

  // ---------------- clock / reset ----------------
  always #5 in_clock = ~in_clock;

  task automatic model_reset();
    for (int i = 0; i < RC; i++) m_rg[i] = 0;
    m_f = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [W-1:0] e;
    for (int i = 0; i < RC; i++) begin
      in_rd_addr_a = RW'(i);
      in_rd_addr_b = RW'(RC - 1 - i);
      exp_q.push_back(W'(m_rg[i]));
      exp_q.push_back(W'(m_rg[RC - 1 - i]));
      #1;
      e = exp_q.pop_front();
      check({tag, "_rd_a"}, out_rd_data_a, e);
      e = exp_q.pop_front();
      check({tag, "_rd_b"}, out_rd_data_b, e);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic bit is_shift(input int op);
    return (op == 7) || (op == 8) || (op == 9);
  endfunction

  task automatic model_exec(input int op, input int a, input int b, input int c,
                            output int res, output int fl, output bit wr,
                            output bit ill, output int n);
    int cf, vf, s, v;
    cf = 0; vf = 0; res = 0; wr = 1; ill = 0; n = 0;
    case (op)
      0, 5: begin
        s   = a + b + ((op == 5) ? c : 0);
        res = s % 256;
        cf  = (s > 255);
        s   = sx(a) + sx(b) + ((op == 5) ? c : 0);
        vf  = (s > 127) || (s < -128);
      end
      1, 6, 10: begin
        s   = a - b - ((op == 6) ? c : 0);
        res = (s + 512) % 256;
        cf  = (a < b + ((op == 6) ? c : 0));
        s   = sx(a) - sx(b) - ((op == 6) ? c : 0);
        vf  = (s > 127) || (s < -128);
        wr  = (op != 10);
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      7, 8, 9: begin
        n = (b > W) ? W : b;
        v = a;
        for (int k = 0; k < n; k++) begin
          if (op == 7) begin
            cf = (v >> 7) & 1;
            v  = (v << 1) & 255;
          end else if (op == 8) begin
            cf = v & 1;
            v  = v >> 1;
          end else begin
            cf = v & 1;
            v  = (v >> 1) | (v & 128);
          end
        end
        res = v;
      end
      default: begin
        wr  = 0;
        ill = 1;
      end
    endcase
    fl = ill ? 0 : ((res == 0) ? 1 : 0) | ((res >= 128) ? 2 : 0) | (cf << 2) | (vf << 3);
  endtask

  // ---------------- driver tasks ----------------
  task automatic ext_write(input int addr, input int data);
    @(negedge in_clock);
    in_wr_en   = 1'b1;
    in_wr_addr = RW'(addr);
    in_wr_data = W'(data);
    @(posedge in_clock);
    #1 in_wr_en = 1'b0;
    m_rg[addr] = data & 255;
  endtask

  task automatic flag_write(input int data);
    @(negedge in_clock);
    in_flags_wr_en = 1'b1;
    in_flags_data  = W'(data);
    @(posedge in_clock);
    #1 in_flags_wr_en = 1'b0;
    m_f = data & 15;
  endtask

  task automatic do_op(input int op, input int dst, input int src,
                       input bit ext_en = 0, input int ext_addr = 0, input int ext_data = 0,
                       input bit fw_en = 0, input int fw_data = 0,
                       input bit mid_en = 0, input int mid_addr = 0, input int mid_data = 0);
    int res, fl, n, lat, t, cycles;
    bit wr, ill, serial, seen;
    t = 0;
    while (!out_op_ready && t < 50) begin
      @(negedge in_clock);
      t++;
    end
    check("ready_before_op", out_op_ready, 1);
    model_exec(op, m_rg[dst], m_rg[src], (m_f >> 2) & 1, res, fl, wr, ill, n);
    serial = is_shift(op) && (n > 0);
    lat    = serial ? n : 0;
    @(negedge in_clock);
    in_op_valid    = 1'b1;
    in_op          = 4'(op);
    in_dst         = RW'(dst);
    in_src         = RW'(src);
    in_wr_en       = ext_en;
    in_wr_addr     = RW'(ext_addr);
    in_wr_data     = W'(ext_data);
    in_flags_wr_en = fw_en;
    in_flags_data  = W'(fw_data);
    @(posedge in_clock);
    #1;
    in_op_valid    = 1'b0;
    in_wr_en       = 1'b0;
    in_flags_wr_en = 1'b0;
    cycles = 0;
    seen   = 0;
    while (cycles <= 40) begin
      @(negedge in_clock);
      if (out_done) begin
        seen = 1;
        break;
      end
      check("ready_low_while_busy", out_op_ready, 0);
      if (cycles == 0 && mid_en) begin
        in_wr_en   = 1'b1;
        in_wr_addr = RW'(mid_addr);
        in_wr_data = W'(mid_data);
      end else begin
        in_wr_en = 1'b0;
      end
      cycles++;
    end
    in_wr_en = 1'b0;
    check("done_seen", seen, 1);
    check("done_latency", cycles, lat);
    check("illegal_pulse", out_illegal, ill);
    check("ready_at_done", out_op_ready, 1);
    if (ext_en) m_rg[ext_addr] = ext_data & 255;
    if (fw_en) m_f = fw_data & 15;
    if (serial && mid_en) m_rg[mid_addr] = mid_data & 255;
    if (wr) m_rg[dst] = res;
    if (!ill) m_f = fl;
    check("flags", out_flags, m_f);
    check_regs("op");
    @(negedge in_clock);
    check("done_one_cycle", out_done, 0);
    check("illegal_one_cycle", out_illegal, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    in_reset_n     = 1'b0;
    in_op_valid    = 1'b0;
    in_op          = '0;
    in_dst         = '0;
    in_src         = '0;
    in_wr_en       = 1'b0;
    in_wr_addr     = '0;
    in_wr_data     = '0;
    in_flags_wr_en = 1'b0;
    in_flags_data  = '0;
    in_rd_addr_a   = '0;
    in_rd_addr_b   = '0;
    model_reset();
    repeat (3) @(posedge in_clock);
    @(negedge in_clock);
    in_reset_n = 1'b1;

    // Reset state over three idle cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge in_clock);
      check("reset_ready", out_op_ready, 1);
      check("reset_no_done", out_done, 0);
      check("reset_no_illegal", out_illegal, 0);
    end
    check("reset_flags", out_flags, 8'h00);
    check_regs("reset");

    // ADD overflow into sign
    ext_write(1, 8'h7F);
    ext_write(2, 8'h01);
    do_op(0, 1, 2);
    check("add_r1", m_rg[1], 8'h80);
    check("add_flags_const", out_flags, 8'h0A);

    // SUB with borrow, then SBB consuming the carry
    ext_write(3, 8'h00);
    ext_write(4, 8'h01);
    do_op(1, 3, 4);
    check("sub_flags_const", out_flags, 8'h06);
    ext_write(5, 8'h10);
    ext_write(6, 8'h00);
    do_op(6, 5, 6);
    in_rd_addr_a = 3'd5;
    #1 check("sbb_r5_const", out_rd_data_a, 8'h0F);
    check("sbb_flags_const", out_flags, 8'h00);

    // Serial shifts, including clamp of the amount to CPU_WIDTH
    ext_write(0, 8'h90);
    ext_write(7, 3);
    do_op(9, 0, 7);
    in_rd_addr_a = 3'd0;
    #1 check("sar_r0_const", out_rd_data_a, 8'hF2);
    check("sar_flags_const", out_flags, 8'h02);
    ext_write(0, 8'h81);
    ext_write(7, 9);
    do_op(7, 0, 7);
    in_rd_addr_a = 3'd0;
    #1 check("shl9_r0_const", out_rd_data_a, 8'h00);
    check("shl9_flags_const", out_flags, 8'h05);

    // Shift with external writes on accept edge and during SHIFT
    ext_write(7, 2);
    do_op(8, 0, 7, 1, 0, 8'h55, 0, 0, 1, 0, 8'h33);
    ext_write(2, 8'hC4);
    ext_write(6, 1);
    do_op(7, 2, 6, 0, 0, 0, 0, 0, 1, 5, 8'hA5);

    // CMP, illegal opcode, flag restore
    ext_write(1, 8'h05);
    ext_write(2, 8'h05);
    do_op(10, 1, 2);
    check("cmp_flags_const", out_flags, 8'h01);
    do_op(12, 1, 2);
    check("illegal_flags_kept", out_flags, 8'h01);
    flag_write(8'hFF);
    check("flag_restore", out_flags, 8'h0F);
    check_regs("flag_restore");

    // Reset asserted in the middle of a serial shift
    ext_write(0, 8'h81);
    ext_write(7, 5);
    @(negedge in_clock);
    in_op_valid = 1'b1;
    in_op       = 4'd7;
    in_dst      = 3'd0;
    in_src      = 3'd7;
    @(posedge in_clock);
    #1 in_op_valid = 1'b0;
    repeat (2) @(negedge in_clock);
    check("mid_shift_busy", out_op_ready, 0);
    in_reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_ready", out_op_ready, 1);
    check("async_reset_flags", out_flags, 0);
    check_regs("async_reset");
    repeat (2) begin
      @(negedge in_clock);
      check("reset_hold_no_done", out_done, 0);
    end
    in_reset_n = 1'b1;
    repeat (6) begin
      @(negedge in_clock);
      check("after_reset_no_done", out_done, 0);
      check("after_reset_ready", out_op_ready, 1);
    end
    check_regs("after_reset");

    // Same-edge external write and ADD writeback to R1
    ext_write(1, 8'h20);
    ext_write(2, 8'h03);
    do_op(0, 1, 2, 1, 1, 8'hEE, 1, 8'h0F);
    in_rd_addr_a = 3'd1;
    #1 check("collide_r1_const", out_rd_data_a, 8'h23);

    // Randomized operations
    for (int k = 0; k < 150; k++) begin
      int op, dst, src;
      op  = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
      dst = $urandom_range(0, RC - 1);
      src = $urandom_range(0, RC - 1);
      if ($urandom_range(0, 2) == 0) ext_write($urandom_range(0, RC - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) flag_write($urandom_range(0, 255));
      if (is_shift(op) && src != dst && $urandom_range(0, 1) == 0)
        ext_write(src, $urandom_range(0, 10));
      do_op(op, dst, src,
            ($urandom_range(0, 4) == 0), $urandom_range(0, RC - 1), $urandom_range(0, 255),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 255),
            ($urandom_range(0, 2) == 0), $urandom_range(0, RC - 1), $urandom_range(0, 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0x0 exp=0x1");
    $fatal(1, "timeout");
  end

endmodule
